// File: rtl/vx_barrier_unit.sv
// Warp-barrier responder: tracks per-slot arrivals and pulses a release mask
// when the last participating warp arrives.

module vx_barrier_slot #(
    parameter int NUM_WARPS = 4,
    parameter int NW_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arrive,
    input  logic [NUM_WARPS-1:0] wbit,
    input  logic [NW_BITS-1:0]   size_m1,
    output logic [NUM_WARPS-1:0] mask,
    output logic                 fire,
    output logic [NUM_WARPS-1:0] fire_wmask
);
    logic               busy;
    logic [NW_BITS-1:0] count;
    logic [NW_BITS-1:0] size;
    logic [NW_BITS-1:0] count_inc;
    logic               last;

    assign count_inc = NW_BITS'(count + 1'b1);
    // an idle slot with size_m1==0 releases immediately without ever going busy
    assign last       = busy ? (count_inc == size) : (size_m1 == '0);
    assign fire       = arrive && last;
    assign fire_wmask = fire ? (mask | wbit) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            mask  <= '0;
            count <= '0;
            size  <= '0;
        end else if (arrive) begin
            if (last) begin
                busy  <= 1'b0;
                mask  <= '0;
                count <= '0;
            end else if (!busy) begin
                busy  <= 1'b1;
                mask  <= wbit;
                count <= '0;
                size  <= size_m1;
            end else begin
                mask  <= mask | wbit;
                count <= count_inc;
            end
        end
    end
endmodule

module vx_barrier_unit #(
    parameter  int NUM_WARPS    = 4,
    parameter  int NUM_BARRIERS = 4,
    localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic [NW_BITS-1:0]   req_wid,
    input  logic [NB_BITS-1:0]   req_id,
    input  logic [NW_BITS-1:0]   req_size_m1,
    output logic                 release_valid,
    output logic [NB_BITS-1:0]   release_id,
    output logic [NUM_WARPS-1:0] release_wmask,
    output logic [NUM_WARPS-1:0] stalled_wmask,
    output logic                 error
);
    typedef struct packed {
        logic                 valid;
        logic [NB_BITS-1:0]   id;
        logic [NUM_WARPS-1:0] wmask;
    } rsp_t;

    logic [NUM_WARPS-1:0]                    wbit;
    logic                                    dup;
    logic [NUM_BARRIERS-1:0]                 slot_fire;
    logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0]  slot_mask;
    logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0]  slot_fire_wmask;
    rsp_t                                    rsp_d;
    rsp_t                                    rsp_q;
    logic                                    error_q;

    assign wbit = NUM_WARPS'(1) << req_wid;
    // a warp already waiting anywhere must not arrive again
    assign dup  = |(stalled_wmask & wbit);

    for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_slot
        vx_barrier_slot #(
            .NUM_WARPS (NUM_WARPS),
            .NW_BITS   (NW_BITS)
        ) u_slot (
            .clk        (clk),
            .reset_n    (reset_n),
            .arrive     (req_valid && !dup && (req_id == NB_BITS'(i))),
            .wbit       (wbit),
            .size_m1    (req_size_m1),
            .mask       (slot_mask[i]),
            .fire       (slot_fire[i]),
            .fire_wmask (slot_fire_wmask[i])
        );
    end

    always_comb begin
        stalled_wmask = '0;
        rsp_d         = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            stalled_wmask = stalled_wmask | slot_mask[i];
            rsp_d.wmask   = rsp_d.wmask | slot_fire_wmask[i];
        end
        // only the addressed slot can fire, so one release per cycle at most
        rsp_d.valid = |slot_fire;
        rsp_d.id    = rsp_d.valid ? req_id : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_q   <= '0;
            error_q <= 1'b0;
        end else begin
            rsp_q   <= rsp_d;
            error_q <= req_valid && dup;
        end
    end

    assign release_valid = rsp_q.valid;
    assign release_id    = rsp_q.id;
    assign release_wmask = rsp_q.wmask;
    assign error         = error_q;
endmodule

// File: tb/tb_vx_barrier_unit.sv
// Directed bench for vx_barrier_unit with 4 warps and 4 barrier slots.

module tb_vx_barrier_unit;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_wid = '0;
    logic [1:0] req_id = '0;
    logic [1:0] req_size_m1 = '0;
    logic       release_valid;
    logic [1:0] release_id;
    logic [3:0] release_wmask;
    logic [3:0] stalled_wmask;
    logic       error;

    int errors = 0;
    int checks = 0;

    vx_barrier_unit #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_wid       (req_wid),
        .req_id        (req_id),
        .req_size_m1   (req_size_m1),
        .release_valid (release_valid),
        .release_id    (release_id),
        .release_wmask (release_wmask),
        .stalled_wmask (stalled_wmask),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rv/rid/rmask/stall/err as seen one edge after the request
    task automatic expect_out(input string tag, input logic rv, input logic [1:0] rid,
                              input logic [3:0] rmask, input logic [3:0] stall, input logic err);
        chk({tag, ".rv"},    8'(release_valid), 8'(rv));
        chk({tag, ".rid"},   8'(release_id),    8'(rid));
        chk({tag, ".rmask"}, 8'(release_wmask), 8'(rmask));
        chk({tag, ".stall"}, 8'(stalled_wmask), 8'(stall));
        chk({tag, ".err"},   8'(error),         8'(err));
    endtask

    task automatic req(input int wid, input int id, input int sm1);
        req_valid   = 1'b1;
        req_wid     = 2'(wid);
        req_id      = 2'(id);
        req_size_m1 = 2'(sm1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        expect_out("reset", 0, 0, 4'h0, 4'h0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 4-warp barrier on slot 0
        req(0, 0, 3); expect_out("b4.w0", 0, 0, 4'h0, 4'h1, 0);
        req(1, 0, 3); expect_out("b4.w1", 0, 0, 4'h0, 4'h3, 0);
        req(2, 0, 3); expect_out("b4.w2", 0, 0, 4'h0, 4'h7, 0);
        req(3, 0, 3); expect_out("b4.w3", 1, 0, 4'hF, 4'h0, 0);
        idle();       expect_out("b4.idle", 0, 0, 4'h0, 4'h0, 0);

        // immediate release
        req(2, 1, 0); expect_out("imm", 1, 1, 4'h4, 4'h0, 0);
        idle();       expect_out("imm.idle", 0, 0, 4'h0, 4'h0, 0);

        // interleaved barriers 0 and 1
        req(0, 0, 1); expect_out("il.a", 0, 0, 4'h0, 4'h1, 0);
        req(1, 1, 1); expect_out("il.b", 0, 0, 4'h0, 4'h3, 0);
        req(2, 1, 1); expect_out("il.c", 1, 1, 4'h6, 4'h1, 0);
        req(3, 0, 1); expect_out("il.d", 1, 0, 4'h9, 4'h0, 0);

        // duplicate arrival is rejected and leaves slot 2 alone
        req(1, 0, 2); expect_out("dup.a", 0, 0, 4'h0, 4'h2, 0);
        req(1, 2, 0); expect_out("dup.b", 0, 0, 4'h0, 4'h2, 1);
        idle();       expect_out("dup.idle", 0, 0, 4'h0, 4'h2, 0);
        req(3, 2, 0); expect_out("dup.bar2", 1, 2, 4'h8, 4'h2, 0);
        req(0, 0, 0); expect_out("dup.c", 0, 0, 4'h0, 4'h3, 0);
        req(2, 0, 0); expect_out("dup.d", 1, 0, 4'h7, 4'h0, 0);

        // reset while warps wait on slot 3
        req(0, 3, 3); expect_out("rst.a", 0, 0, 4'h0, 4'h1, 0);
        req(1, 3, 3); expect_out("rst.b", 0, 0, 4'h0, 4'h3, 0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("rst.async", 0, 0, 4'h0, 4'h0, 0);
        reset_n = 1'b1;
        req(0, 3, 0); expect_out("rst.after", 1, 3, 4'h1, 4'h0, 0);

        // back-to-back reuse of slot 0
        req(0, 0, 1); expect_out("reuse.a", 0, 0, 4'h0, 4'h1, 0);
        req(1, 0, 1); expect_out("reuse.b", 1, 0, 4'h3, 4'h0, 0);
        req(2, 0, 1); expect_out("reuse.c", 0, 0, 4'h0, 4'h4, 0);
        req(3, 0, 1); expect_out("reuse.d", 1, 0, 4'hC, 4'h0, 0);
        idle();       expect_out("reuse.idle", 0, 0, 4'h0, 4'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
